// File: rtl/mod_n_cascade_counter_pkg.sv
// mod_n_cascade_counter_pkg: shared constants and width helper for the cascade counter
package mod_n_cascade_counter_pkg;
  localparam int MOD_MIN = 2;
  localparam int MOD_MAX = 16;
  localparam int DIGITS_MAX = 8;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/mod_n_digit.sv
// mod_n_digit: one modulo-MOD up/down digit with clamped parallel load and terminal-count flags
module mod_n_digit import mod_n_cascade_counter_pkg::*; #(
  parameter int MOD = 10,
  parameter int W = clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         tc_up,
  output logic         tc_dn
);
  localparam logic [W-1:0] TOP = W'(MOD - 1);
  assign tc_up = q == TOP;
  assign tc_dn = q == '0;
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else if (load) q <= load_val > TOP ? TOP : load_val;
    else if (en) q <= up ? (tc_up ? '0 : q + 1'b1) : (tc_dn ? TOP : q - 1'b1);
endmodule

// File: rtl/mod_n_cascade_counter.sv
// mod_n_cascade_counter: DIGITS cascaded modulo-MOD digits with carry look-ahead, zero detect and wrap pulse
module mod_n_cascade_counter import mod_n_cascade_counter_pkg::*; #(
  parameter int DIGITS = 2,
  parameter int MOD = 10,
  localparam int W = clog2(MOD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [DIGITS*W-1:0] load_val,
  output logic [DIGITS*W-1:0] cnt,
  output logic              cr,
  output logic              zero,
  output logic              wrap
);
  if (MOD < MOD_MIN || MOD > MOD_MAX || DIGITS < 1 || DIGITS > DIGITS_MAX) begin : g_bad
    $error("mod_n_cascade_counter: MOD or DIGITS out of range");
  end
  logic [DIGITS-1:0] tc_up, tc_dn;
  logic [DIGITS:0] all_up, all_dn;
  assign all_up[0] = 1'b1;
  assign all_dn[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    mod_n_digit #(.MOD(MOD), .W(W)) u_dig (
      .clk(clk),
      .rst(rst),
      .en(en & (up ? all_up[i] : all_dn[i])),
      .up(up),
      .load(load),
      .load_val(load_val[i*W +: W]),
      .q(cnt[i*W +: W]),
      .tc_up(tc_up[i]),
      .tc_dn(tc_dn[i])
    );
    assign all_up[i+1] = all_up[i] & tc_up[i];
    assign all_dn[i+1] = all_dn[i] & tc_dn[i];
  end
  assign cr = en & (up ? all_up[DIGITS] : all_dn[DIGITS]);
  assign zero = all_dn[DIGITS];
  always_ff @(posedge clk)
    wrap <= rst & ~load & cr;
endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// tb_mod_n_cascade_counter: vector table, corner sequences, random model check and a chained pair
module tb_mod_n_cascade_counter;
  logic clk = 1'b0, rst, en, up, load, hi_load;
  logic [7:0] lv, cnt, hi_cnt;
  logic cr, zero, wrap, hi_cr, hi_zero, hi_wrap;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mod_n_cascade_counter #(.DIGITS(2), .MOD(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .cnt(cnt), .cr(cr), .zero(zero), .wrap(wrap)
  );

  mod_n_cascade_counter #(.DIGITS(2), .MOD(10)) u_hi (
    .clk(clk), .rst(rst), .en(cr), .up(up), .load(hi_load), .load_val(8'h00),
    .cnt(hi_cnt), .cr(hi_cr), .zero(hi_zero), .wrap(hi_wrap)
  );

  typedef struct {
    logic r, l, e, u;
    logic [7:0] lv;
    logic [7:0] cnt;
    logic wrap, zero;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic u, input logic [7:0] v);
    rst = r; load = l; en = e; up = u; lv = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] bcd4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  vec_t tbl[13];
  int v, w, pulses, err;
  logic r, l, e, u, cr_pre;
  logic [7:0] rv;

  initial begin
    hi_load = 1'b0;
    drive(0, 0, 0, 1, 8'h00);
    tick; tick;
    chk("reset_cnt", cnt, 0);
    chk("reset_wrap", wrap, 0);
    chk("reset_zero", zero, 1);
    en = 1; up = 0; #1;
    chk("reset_cr_dn", cr, 1);
    up = 1; #1;
    chk("reset_cr_up", cr, 0);

    tbl[0]  = '{1, 1, 0, 1, 8'h3C, 8'h39, 0, 0};
    tbl[1]  = '{1, 0, 1, 1, 8'h00, 8'h40, 0, 0};
    tbl[2]  = '{1, 1, 0, 1, 8'h19, 8'h19, 0, 0};
    tbl[3]  = '{1, 1, 1, 1, 8'h05, 8'h05, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 8'h57, 8'h57, 0, 0};
    tbl[5]  = '{0, 1, 1, 1, 8'h12, 8'h00, 0, 1};
    tbl[6]  = '{1, 0, 1, 0, 8'h00, 8'h99, 1, 0};
    tbl[7]  = '{1, 0, 1, 0, 8'h00, 8'h98, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 8'hFF, 8'h99, 0, 0};
    tbl[9]  = '{1, 0, 1, 1, 8'h00, 8'h00, 1, 1};
    tbl[10] = '{1, 0, 0, 1, 8'h00, 8'h00, 0, 1};
    tbl[11] = '{1, 1, 1, 0, 8'hA9, 8'h99, 0, 0};
    tbl[12] = '{1, 0, 0, 1, 8'h00, 8'h99, 0, 0};
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].l, tbl[i].e, tbl[i].u, tbl[i].lv);
      tick;
      chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].cnt);
      chk($sformatf("vec%0d_wrap", i), wrap, tbl[i].wrap);
      chk($sformatf("vec%0d_zero", i), zero, tbl[i].zero);
    end

    drive(0, 0, 0, 1, 8'h00);
    tick;
    drive(1, 0, 1, 1, 8'h00);
    #1;
    err = 0;
    for (int i = 0; i < 100; i++) begin
      if (cnt !== bcd(i) || cr !== (i == 99) || wrap !== 1'b0) err++;
      tick;
    end
    chk("uprun_steps", err, 0);
    chk("uprun_cnt", cnt, 8'h00);
    chk("uprun_wrap", wrap, 1);
    tick;
    chk("uprun_wrap_end", wrap, 0);
    chk("uprun_cnt1", cnt, 8'h01);

    drive(0, 0, 0, 1, 8'h00);
    tick;
    drive(1, 0, 1, 0, 8'h00);
    #1;
    chk("dn_cr0", cr, 1);
    chk("dn_zero0", zero, 1);
    tick;
    chk("dn_cnt99", cnt, 8'h99);
    chk("dn_wrap", wrap, 1);
    chk("dn_cr99", cr, 0);
    tick;
    chk("dn_cnt98", cnt, 8'h98);
    chk("dn_wrap_end", wrap, 0);

    drive(0, 0, 0, 1, 8'h00);
    tick;
    v = 0; w = 0;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 31) != 0;
      l = $urandom_range(0, 7) == 0;
      e = $urandom_range(0, 3) != 0;
      u = 1'($urandom);
      rv = 8'($urandom);
      drive(r, l, e, u, rv);
      #1;
      cr_pre = e & (u ? v == 99 : v == 0);
      chk("rnd_cr", cr, cr_pre);
      chk("rnd_zero", zero, v == 0);
      tick;
      w = r & ~l & cr_pre;
      if (!r) v = 0;
      else if (l) v = (rv[7:4] > 9 ? 9 : rv[7:4]) * 10 + (rv[3:0] > 9 ? 9 : rv[3:0]);
      else if (e) v = u ? (v + 1) % 100 : (v + 99) % 100;
      chk("rnd_cnt", cnt, bcd(v));
      chk("rnd_wrap", wrap, w);
    end

    drive(0, 0, 0, 1, 8'h00);
    tick;
    drive(1, 0, 1, 1, 8'h00);
    pulses = 0; err = 0;
    for (int i = 1; i <= 10000; i++) begin
      tick;
      if ({hi_cnt, cnt} !== bcd4(i % 10000)) err++;
      if (hi_wrap) pulses++;
    end
    chk("chain_cnt", err, 0);
    chk("chain_final", {hi_cnt, cnt}, 16'h0000);
    tick;
    if (hi_wrap) pulses++;
    chk("chain_hi_wrap_pulses", pulses, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
